// File: rtl/jk_seq_driver.sv
// jk_seq_driver: steps a JK flip-flop through a loaded target pattern, one bit
// every two cycles (DRIVE then CHECK). It logs the Q it reads back and counts
// the bits that missed the target.
module jk_seq_driver #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter bit MODE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic             q_in,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0] q_log
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // J/K needed to move Q to tgt. Drive 00 when Q already matches.
  function automatic logic [1:0] excite(input logic tgt, input logic q);
    logic [1:0] jk;
    if (tgt == q) begin
      jk = 2'b00;
    end else if (MODE) begin
      jk = 2'b11;
    end else begin
      jk = {tgt, ~tgt};
    end
    return jk;
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] pat_r, pat_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [IDX_W-1:0] idx_nx_s;
  logic             tgt_s;
  logic             j_r, j_s;
  logic             k_r, k_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [CNT_W-1:0] err_r, err_s;
  logic [WIDTH-1:0] qlog_r, qlog_s;

  // Target bit for the current index and the index of the following bit.
  always_comb begin
    idx_nx_s = idx_r + IDX_W'(1);
    tgt_s    = pat_r[idx_r];
  end

  // Next-state and next-output logic. J/K default to hold (00) outside DRIVE.
  always_comb begin
    state_s = state_r;
    pat_s   = pat_r;
    idx_s   = idx_r;
    j_s     = 1'b0;
    k_s     = 1'b0;
    busy_s  = busy_r;
    done_s  = 1'b0;
    err_s   = err_r;
    qlog_s  = qlog_r;
    case (state_r)
      S_IDLE: begin
        busy_s = 1'b0;
        if (start) begin
          pat_s      = pattern;
          idx_s      = {IDX_W{1'b0}};
          err_s      = {CNT_W{1'b0}};
          qlog_s     = {WIDTH{1'b0}};
          {j_s, k_s} = excite(pattern[0], q_in);
          busy_s     = 1'b1;
          state_s    = S_DRIVE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_DRIVE: begin
        busy_s  = 1'b1;
        state_s = S_CHECK;
      end
      S_CHECK: begin
        busy_s        = 1'b1;
        qlog_s[idx_r] = q_in;
        if ((q_in != tgt_s) && (err_r != ERR_MAX)) begin
          err_s = err_r + CNT_W'(1);
        end else begin
          err_s = err_r;
        end
        if (idx_r == LAST_IDX) begin
          done_s  = 1'b1;
          state_s = S_DONE;
        end else begin
          // Q has settled, so the next bit's excitation is computed from it.
          idx_s      = idx_nx_s;
          {j_s, k_s} = excite(pat_r[idx_nx_s], q_in);
          state_s    = S_DRIVE;
        end
      end
      S_DONE: begin
        busy_s  = 1'b0;
        state_s = S_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = S_IDLE;
      end
    endcase
  end

  // State and output registers. Reset discards any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      pat_r   <= {WIDTH{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      j_r     <= 1'b0;
      k_r     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= {CNT_W{1'b0}};
      qlog_r  <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      pat_r   <= pat_s;
      idx_r   <= idx_s;
      j_r     <= j_s;
      k_r     <= k_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      err_r   <= err_s;
      qlog_r  <= qlog_s;
    end
  end

  assign j       = j_r;
  assign k       = k_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign err_cnt = err_r;
  assign q_log   = qlog_r;

endmodule

// File: tb/tb_jk_seq_driver.sv
// Bench for jk_seq_driver. Three instances share start/pattern:
//   d0: MODE=0, CNT_W=4, behavioural JK flop or Q stuck at 0 (selectable)
//   d1: MODE=1, CNT_W=4, behavioural JK flop
//   d2: MODE=0, CNT_W=2, Q stuck at 0 (saturation)
// Expected values come from a bit-level model of the run's rules.
module tb_jk_seq_driver;

  localparam int W = 8;

  logic clk, rst_n, start, ff_clr, stuck0;
  logic [W-1:0] pattern;
  logic q_in_a [3];
  logic j_a [3], k_a [3], busy_a [3], done_a [3];
  logic [W-1:0] qlog_a [3];
  logic [3:0] err_a [3];
  logic [3:0] err0, err1;
  logic [1:0] err2;
  int n_cmp = 0;
  int n_bad = 0;

  jk_seq_driver #(.WIDTH(W), .CNT_W(4), .MODE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .q_in(q_in_a[0]),
    .j(j_a[0]), .k(k_a[0]), .busy(busy_a[0]), .done(done_a[0]),
    .err_cnt(err0), .q_log(qlog_a[0]));
  jk_seq_driver #(.WIDTH(W), .CNT_W(4), .MODE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .q_in(q_in_a[1]),
    .j(j_a[1]), .k(k_a[1]), .busy(busy_a[1]), .done(done_a[1]),
    .err_cnt(err1), .q_log(qlog_a[1]));
  jk_seq_driver #(.WIDTH(W), .CNT_W(2), .MODE(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .q_in(q_in_a[2]),
    .j(j_a[2]), .k(k_a[2]), .busy(busy_a[2]), .done(done_a[2]),
    .err_cnt(err2), .q_log(qlog_a[2]));

  assign err_a[0] = err0;
  assign err_a[1] = err1;
  assign err_a[2] = {2'b00, err2};

  // Behavioural JK flip-flops driven by each instance.
  for (genvar g = 0; g < 3; g++) begin : g_ff
    logic q_r;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_r <= 1'b0;
      else if (ff_clr) q_r <= 1'b0;
      else begin
        case ({j_a[g], k_a[g]})
          2'b01:   q_r <= 1'b0;
          2'b10:   q_r <= 1'b1;
          2'b11:   q_r <= ~q_r;
          default: q_r <= q_r;
        endcase
      end
    end
    assign q_in_a[g] = ((g == 2) || ((g == 0) && stuck0)) ? 1'b0 : q_r;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  // Run outcome from the rules: a working flop reaches every target, a
  // stuck flop reads 0; J/K depend on target versus Q before the bit.
  task automatic model(input int d, input logic [W-1:0] pat, input logic q0,
                       output logic [W-1:0] eq, output logic [3:0] ee, output logic [2*W-1:0] ejk);
    bit   stuck = (d == 2) || ((d == 0) && stuck0);
    int   sat   = (d == 2) ? 3 : 15;
    int   miss  = 0;
    logic prev  = stuck ? 1'b0 : q0;
    for (int i = 0; i < W; i++) begin
      logic t = pat[i];
      logic qi = stuck ? 1'b0 : t;
      if (t == prev) ejk[2*i +: 2] = 2'b00;
      else if (d == 1) ejk[2*i +: 2] = 2'b11;
      else ejk[2*i +: 2] = {t, ~t};
      eq[i] = qi;
      if (qi != t) miss++;
      prev = qi;
    end
    ee = 4'((miss > sat) ? sat : miss);
  endtask

  task automatic chk_quiet(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk({tag, "_j"}, d, 32'(j_a[d]), 32'd0);
      chk({tag, "_k"}, d, 32'(k_a[d]), 32'd0);
      chk({tag, "_busy"}, d, 32'(busy_a[d]), 32'd0);
      chk({tag, "_done"}, d, 32'(done_a[d]), 32'd0);
      chk({tag, "_err"}, d, 32'(err_a[d]), 32'd0);
      chk({tag, "_qlog"}, d, 32'(qlog_a[d]), 32'd0);
    end
  endtask

  // One full run, sampled 1ns after every edge from the start edge
  // (cycle 0) to the edge after DONE (cycle 2W+1).
  task automatic do_run(input logic [W-1:0] pat, input logic q0, input bit hold, input bit clr);
    logic [W-1:0]   eq  [3];
    logic [3:0]     ee  [3];
    logic [2*W-1:0] ejk [3];
    logic q0_use = q0;
    if (clr) begin
      ff_clr = 1'b1;
      @(posedge clk); #1;
      ff_clr = 1'b0;
      q0_use = 1'b0;
    end
    for (int d = 0; d < 3; d++) model(d, pat, q0_use, eq[d], ee[d], ejk[d]);
    pattern = pat;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    pattern = ~pat;
    for (int d = 0; d < 3; d++) begin
      chk("c0_busy", d, 32'(busy_a[d]), 32'd1);
      chk("c0_err_clr", d, 32'(err_a[d]), 32'd0);
      chk("c0_qlog_clr", d, 32'(qlog_a[d]), 32'd0);
      chk("c0_jk", d, 32'({j_a[d], k_a[d]}), 32'(ejk[d][1:0]));
    end
    for (int c = 1; c <= 2*W+1; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        if (c == 2*W+1) begin
          chk("end_busy", d, 32'(busy_a[d]), 32'd0);
          chk("end_done", d, 32'(done_a[d]), 32'd0);
          chk("end_err", d, 32'(err_a[d]), 32'(ee[d]));
          chk("end_qlog", d, 32'(qlog_a[d]), 32'(eq[d]));
        end else if (c == 2*W) begin
          chk("done_pulse", d, 32'(done_a[d]), 32'd1);
          chk("done_busy", d, 32'(busy_a[d]), 32'd1);
          chk("done_jk", d, 32'({j_a[d], k_a[d]}), 32'd0);
        end else if (c % 2 == 1) begin
          chk("chk_jk", d, 32'({j_a[d], k_a[d]}), 32'd0);
          chk("chk_done", d, 32'(done_a[d]), 32'd0);
          chk("chk_busy", d, 32'(busy_a[d]), 32'd1);
        end else begin
          chk("drv_jk", d, 32'({j_a[d], k_a[d]}), 32'(ejk[d][c +: 2]));
          chk("drv_done", d, 32'(done_a[d]), 32'd0);
        end
      end
    end
  endtask

  initial begin
    logic [W-1:0] pa;
    rst_n = 1'b0; start = 1'b0; ff_clr = 1'b0; stuck0 = 1'b0; pattern = '0;
    repeat (3) @(posedge clk);
    #1 chk_quiet("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    do_run(8'hB2, 1'b0, 1'b0, 1'b1);            // set/reset, real flop
    stuck0 = 1'b1;
    do_run(8'hB2, 1'b0, 1'b0, 1'b1);            // Q stuck at 0
    stuck0 = 1'b0;
    do_run(8'h55, 1'b0, 1'b0, 1'b1);
    do_run(8'hFF, 1'b0, 1'b0, 1'b1);            // d2 saturates at 3
    for (int r = 0; r < 6; r++) begin
      pa = 8'($urandom);
      stuck0 = 1'($urandom_range(0, 1));
      do_run(pa, 1'b0, 1'b0, 1'b1);
    end
    stuck0 = 1'b0;

    // start held through a run (with the pattern scrambled mid-run);
    // the next run is accepted straight after DONE.
    do_run(8'hC7, 1'b0, 1'b1, 1'b1);
    do_run(8'h1A, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of CHECK for bit 3.
    pattern = 8'hB2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_quiet("async_rst");
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_quiet("post_rst_idle");
    do_run(8'h3C, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jk_seq_driver.md
Name: jk_seq_driver

Overview:
- Sequencer that drives a JK flip-flop so its Q output follows a loaded target bit pattern.
- Drives J/K, reads Q back from the flip-flop, and counts bits where Q missed the target.
- Sits opposite the JK flip-flop: this block produces the J/K inputs and consumes Q. Used for on-chip flip-flop exercise and self-check.

Parameters:
- WIDTH, 8, number of pattern bits per run (≥1)
- CNT_W, 4, width of mismatch counter (saturating)
- MODE, 0, excitation encoding: 0 = set/reset (J=1,K=0 / J=0,K=1), 1 = toggle (J=K=1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  run request, sampled only in IDLE
- pattern  in  WIDTH  target Q sequence, LSB applied first, latched on accepted start
- q_in  in  1  Q fed back from driven flip-flop
- j  out  1  registered J drive
- k  out  1  registered K drive
- busy  out  1  high from accepted start until DONE exit
- done  out  1  one-cycle pulse at end of run
- err_cnt  out  CNT_W  saturating count of mismatched bits of last run
- q_log  out  WIDTH  sampled Q per bit of last run, bit i = Q after bit i applied

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset (any time, including mid-run): state=IDLE, j=k=0, busy=0, done=0, err_cnt=0, q_log=0, internal shift/index=0. No partial result is kept.
- All outputs are registered. J/K excitation for target bit t with current Q=q_in:
  - t==q: j=0, k=0 (hold).
  - t!=q, MODE=0: j=t, k=~t.
  - t!=q, MODE=1: j=1, k=1.
- FSM states IDLE, DRIVE, CHECK, DONE.
- IDLE: j=k=0, busy=0.
  - On an edge with start=1: latch pattern into shift register, idx=0, err_cnt=0, q_log=0.
  - At the same edge, compute j/k for pattern[0] against q_in. Set busy=1, go DRIVE.
- DRIVE (1 cycle): j/k are stable, and the flip-flop samples them at the exiting edge.
  - At that exiting edge: j=k=0, go CHECK.
- CHECK (1 cycle): q_in now reflects the applied bit. At the exiting edge:
  - q_log[idx]=q_in.
  - If q_in != target bit: err_cnt++, saturating at 2^CNT_W-1.
  - If idx==WIDTH-1: go DONE.
  - Otherwise: idx++, compute j/k for the next bit from q_in, go DRIVE.
- DONE (1 cycle): done=1, busy=1, j=k=0. At the next edge: done=0, busy=0, go IDLE.
- Timing:
  - Per bit: 2 cycles.
  - done is high during cycle 2*WIDTH after the start edge (start edge = cycle 0).
  - A new start can be accepted on the edge ending DONE+1, i.e. in IDLE.
- start while busy is ignored. pattern changes after the start edge have no effect.
- err_cnt and q_log hold their values after done until the next accepted start or reset.
- j/k never change during DRIVE. j=k=0 in every non-DRIVE state, so the flip-flop holds.

Test Plan:
- MODE=0, WIDTH=8, real JK flip-flop reset to Q=0, pattern=8'b1011_0010 -> j/k per bit (0,1,0,0,1,1,0,1 LSB first): hold, set, reset, hold, set, hold, reset, set. Expected: q_log=8'hB2, err_cnt=0, done at cycle 16.
- Same pattern with q_in tied to 0 -> err_cnt=4, q_log=0. j=1,k=0 is driven in every DRIVE whose target is 1.
- MODE=1, real flip-flop, pattern=8'b0101_0101 from Q=0 -> j=k=1 in all 8 DRIVE cycles, q_log=8'h55, err_cnt=0.
- CNT_W=2, q_in stuck 0, pattern=8'hFF -> err_cnt saturates at 3 (not wrapping), done still pulses at cycle 16.
- start held high through a whole run, second start raised while busy -> exactly one run per accepted IDLE start; the mid-run start is ignored. A second run begins only after DONE, and err_cnt clears on its start edge.
- rst_n low asynchronously during the CHECK of bit 3 -> j=k=busy=done=0 and err_cnt=q_log=0 immediately, without a clock edge. After release, the FSM stays in IDLE until the next start.
